// File: rtl/eld_pkg.sv
// Shared types and default widths for the ELD lab timer/counter blocks.
// Provides the timer state enum and the default count/prescale widths.
package eld_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam int TIMER_W = 8;
    localparam int PRE_W   = 8;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle of the down timer.
// master: load, load_val, start, stop, auto_reload, prescale out;
// count, busy, done in. slave: the mirror image (the timer itself).
interface down_timer_if
    import eld_pkg::*;
#(
    parameter int WIDTH = TIMER_W,
    parameter int PRE_W = eld_pkg::PRE_W
) ();

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, stop, auto_reload, prescale,
        input  count, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, auto_reload, prescale,
        output count, busy, done
    );

endinterface

// File: rtl/down_timer_prescaler.sv
// Prescale divider: one tick every prescale_i+1 enabled clocks.
// Ports: clock, reset, enable_i, clear_i, prescale_i in; tick_o out.
module prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [PRE_W-1:0] prescale_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] pcnt_q;
    logic [PRE_W-1:0] pcnt_d;

    // >= rather than == so lowering prescale mid-interval cannot
    // leave pcnt above the limit and run it all the way round.
    assign tick_o = enable_i && (pcnt_q >= prescale_i);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clear_i) begin
            pcnt_d = '0;
        end else if (enable_i) begin
            pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable prescaled down-timer with one-cycle done pulse and auto-reload.
// Ports: clock, reset (sync, active-high), bus (down_timer_if.slave).
module down_timer
    import eld_pkg::*;
#(
    parameter int WIDTH = TIMER_W,
    parameter int PRE_W = eld_pkg::PRE_W
) (
    input  logic         clock,
    input  logic         reset,
    down_timer_if.slave  bus
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    logic running;
    logic start_acc;
    logic tick;
    logic terminal;
    logic clear;

    assign running   = (state_q == RUN);
    assign start_acc = bus.start && !bus.stop && !bus.load
                       && !running && (count_q != '0);
    assign terminal  = running && tick && !bus.load && !bus.stop
                       && (count_q == WIDTH'(1));
    assign clear     = bus.load || bus.stop || start_acc || terminal;

    prescaler #(
        .PRE_W (PRE_W)
    ) u_pre (
        .clock      (clock),
        .reset      (reset),
        .enable_i   (running),
        .clear_i    (clear),
        .prescale_i (bus.prescale),
        .tick_o     (tick)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = IDLE;
        end else if (bus.stop) begin
            state_d = IDLE;
        end else if (start_acc) begin
            state_d = RUN;
        end else if (running && tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - 1'b1;
            end else if (terminal) begin
                done_d = 1'b1;
                if (bus.auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = running;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed and randomized bench for down_timer against a cycle model.
// Drives the interface as master; checks count, busy and done each edge.
module tb_down_timer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    down_timer_if #(.WIDTH(8), .PRE_W(8)) bus ();

    down_timer #(.WIDTH(8), .PRE_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: plain integers following the timer rules.
    int m_cnt = 0;
    int m_rel = 0;
    int m_elapsed = 0;
    bit m_run = 0;
    bit m_done = 0;

    task automatic model_edge();
        m_done = 0;
        if (reset) begin
            m_cnt = 0; m_rel = 0; m_run = 0; m_elapsed = 0;
        end else if (bus.load) begin
            m_cnt = int'(bus.load_val);
            m_rel = m_cnt;
            m_run = 0;
            m_elapsed = 0;
        end else if (bus.stop) begin
            m_run = 0;
            m_elapsed = 0;
        end else if (bus.start && !m_run) begin
            if (m_cnt != 0) begin
                m_run = 1;
                m_elapsed = 0;
            end
        end else if (m_run) begin
            if (m_elapsed >= int'(bus.prescale)) begin
                m_elapsed = 0;
                if (m_cnt > 1) begin
                    m_cnt--;
                end else begin
                    m_done = 1;
                    if (bus.auto_reload && m_rel != 0) m_cnt = m_rel;
                    else begin
                        m_cnt = 0;
                        m_run = 0;
                    end
                end
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic checkv(string tag, int got, int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clock);
            #1;
            checkv("m_count", int'(bus.count), m_cnt);
            checkv("m_busy", int'(bus.busy), int'(m_run));
            checkv("m_done", int'(bus.done), int'(m_done));
        end
    endtask

    task automatic idle_inputs();
        bus.load = 0; bus.start = 0; bus.stop = 0;
    endtask

    task automatic do_load(int v);
        bus.load = 1; bus.load_val = 8'(v);
        cyc();
        bus.load = 0;
    endtask

    task automatic do_start();
        bus.start = 1;
        cyc();
        bus.start = 0;
    endtask

    int k;

    initial begin
        bus.load = 0; bus.load_val = '0; bus.start = 0; bus.stop = 0;
        bus.auto_reload = 0; bus.prescale = '0;

        // reset state
        reset = 1; cyc(); reset = 0;
        checkv("rst_count", int'(bus.count), 0);
        checkv("rst_busy", int'(bus.busy), 0);
        checkv("rst_done", int'(bus.done), 0);

        // reset mid-run
        do_load(5); do_start(); cyc(2);
        checkv("mid_busy", int'(bus.busy), 1);
        reset = 1; cyc(); reset = 0;
        checkv("mrst_count", int'(bus.count), 0);
        checkv("mrst_busy", int'(bus.busy), 0);
        checkv("mrst_done", int'(bus.done), 0);
        do_start();
        checkv("zstart_busy", int'(bus.busy), 0);

        // basic countdown
        bus.prescale = 0;
        do_load(3); do_start();
        checkv("b_E_count", int'(bus.count), 3);
        cyc(); checkv("b_E1", int'(bus.count), 2);
        cyc(); checkv("b_E2", int'(bus.count), 1);
        checkv("b_E2_done", int'(bus.done), 0);
        cyc(); checkv("b_E3", int'(bus.count), 0);
        checkv("b_E3_done", int'(bus.done), 1);
        checkv("b_E3_busy", int'(bus.busy), 0);
        cyc(); checkv("b_E4_done", int'(bus.done), 0);

        // prescaled
        bus.prescale = 2;
        do_load(2); do_start();
        cyc(2); checkv("p_E2", int'(bus.count), 2);
        cyc(); checkv("p_E3", int'(bus.count), 1);
        cyc(2); checkv("p_E5", int'(bus.count), 1);
        cyc(); checkv("p_E6", int'(bus.count), 0);
        checkv("p_E6_done", int'(bus.done), 1);

        // auto-reload
        bus.prescale = 0; bus.auto_reload = 1;
        do_load(2); do_start();
        for (int p = 0; p < 3; p++) begin
            cyc(); checkv("ar_c1", int'(bus.count), 1);
            checkv("ar_d0", int'(bus.done), 0);
            cyc(); checkv("ar_c2", int'(bus.count), 2);
            checkv("ar_d1", int'(bus.done), 1);
            checkv("ar_busy", int'(bus.busy), 1);
        end
        bus.auto_reload = 0;
        cyc(); checkv("ar_off1", int'(bus.count), 1);
        cyc(); checkv("ar_off0", int'(bus.count), 0);
        checkv("ar_off_done", int'(bus.done), 1);
        checkv("ar_off_busy", int'(bus.busy), 0);

        // stop / resume / priority
        do_load(10); do_start(); cyc(4);
        bus.stop = 1; cyc(); bus.stop = 0;
        checkv("st_count", int'(bus.count), 6);
        checkv("st_busy", int'(bus.busy), 0);
        checkv("st_done", int'(bus.done), 0);
        do_start();
        cyc(); checkv("rs_5", int'(bus.count), 5);
        cyc(); checkv("rs_4", int'(bus.count), 4);
        bus.stop = 1; cyc();
        bus.start = 1; cyc(); idle_inputs();
        checkv("ss_busy", int'(bus.busy), 0);
        bus.load = 1; bus.start = 1; bus.load_val = 7; cyc(); idle_inputs();
        checkv("ls_count", int'(bus.count), 7);
        checkv("ls_busy", int'(bus.busy), 0);

        // full-scale load
        do_load(255); do_start();
        k = 0;
        do begin
            cyc(); k++;
        end while (!bus.done && k < 300);
        checkv("ff_edges", k, 255);
        do_load(0); do_start();
        checkv("z_busy", int'(bus.busy), 0);
        cyc(); checkv("z_done", int'(bus.done), 0);

        // randomized
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.load = ($urandom_range(0, 15) == 0);
            bus.stop = ($urandom_range(0, 19) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.load_val = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 31) == 0)
                bus.prescale = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
                bus.auto_reload = 1'($urandom);
            cyc();
        end
        reset = 0; idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Synchronous loadable down-counter/timer; the counterpart to the team's free-running ripple up-counter.
- Counts a programmed value down to zero at a prescaled rate.
- Flags terminal count with a one-cycle `done` pulse and optionally auto-reloads.
- Used as the interval/timeout generator alongside the up-counter in the ELD lab designs.

Parameters:
- WIDTH, 8, width of count value and load value
- PRE_W, 8, width of prescale divider field

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- load  input  1  capture load_val into count and reload register
- load_val  input  WIDTH  value to load
- start  input  1  begin counting (IDLE only)
- stop  input  1  halt counting, hold count
- auto_reload  input  1  on terminal count, reload and keep running
- prescale  input  PRE_W  tick every prescale+1 clocks in RUN
- count  output  WIDTH  current count value (registered)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on terminal count (registered)

Behaviour:
- Reset (synchronous, active-high): count=0, reload_reg=0, state=IDLE, pcnt=0, busy=0, done=0. Reset dominates all other inputs.
- States: IDLE, RUN. busy = (state==RUN), registered with state.
- Priority each edge: reset > load > stop > start > tick.
- load, any state:
  - count <= load_val, reload_reg <= load_val, state <= IDLE, pcnt <= 0.
  - A load during RUN aborts the run without a done pulse.
- stop in RUN: state <= IDLE, pcnt <= 0, count held. stop in IDLE has no effect. stop together with start: stop wins, stay or go IDLE.
- start in IDLE:
  - If count != 0: state <= RUN, pcnt <= 0.
  - If count == 0: ignored, no done pulse.
  - start in RUN: ignored.
- Prescaler, RUN only:
  - tick = (pcnt >= prescale). On tick, pcnt <= 0; otherwise pcnt <= pcnt+1.
  - Use >= so a mid-run decrease of prescale cannot cause a wrap.
  - prescale=0 gives a tick every cycle.
- On tick with count > 1: count <= count-1.
- On tick with count == 1 (terminal):
  - done <= 1 for exactly one cycle.
  - If auto_reload=1 and reload_reg != 0: count <= reload_reg, stay RUN, pcnt <= 0.
  - Otherwise: count <= 0, state <= IDLE.
- done is 0 on every cycle other than the terminal update. It is cleared by the next edge regardless of inputs.
- Latency: with start sampled at edge E, the first decrement occurs at edge E+(prescale+1). done goes high at edge E+N·(prescale+1) for loaded value N. count reads 0 on the same cycle done=1 when not reloading.
- count never wraps below 0. The value 0 is never decremented.
- auto_reload is sampled at the terminal tick only.
- prescale and auto_reload may change at any time without corrupting state.

Decomposition:
- Shared package eld_pkg:
  - state enum `timer_state_t` {IDLE, RUN}.
  - Default width constants TIMER_W=8, PRE_W=8.
- One natural sub-module, `prescaler`:
  - Inputs: clock, reset, enable(=busy), clear(=load|stop|start-accept|terminal), prescale.
  - Output: tick.
  - Holds pcnt and the >= compare.
- The top level holds the FSM, count, reload_reg and done.

Test Plan:
- Reset mid-run: load 5, start, after 2 edges assert reset → next edge count=0, busy=0, done=0. A subsequent start is ignored, since count=0.
- Basic countdown, prescale=0, load_val=3, start at edge E → count 2,1,0 at E+1..E+3. done=1 only during the cycle after E+3. busy falls at E+3.
- Prescaled, prescale=2, load_val=2, start at E → count=1 at E+3, count=0 and done=1 at E+6. count stable between ticks.
- Auto-reload, prescale=0, load_val=2, auto_reload=1 → count sequence 2,1,2,1,2… with done pulsing every 2 cycles and busy held high. Deassert auto_reload → next terminal leaves count=0, IDLE.
- Stop/resume and priority:
  - load 10, start, stop after 4 ticks → count=6 held, busy=0, no done.
  - start again → resumes 5,4,…
  - start+stop in the same cycle → remains IDLE.
  - load=1 with start=1 → count=load_val, IDLE.
- Edge values: WIDTH=8, load 8'hFF, prescale=0 → done exactly 255 edges after the start edge. Load 0, start → no busy, no done.
